// File: rtl/spi_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_arb_pkg
//  Description : Shared definitions for the SPI transmit arbiter: arbiter
//                state encoding and default parameter values.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_arb_pkg;

    localparam int unsigned DEF_WIDTH          = 16;
    localparam int unsigned DEF_GAP_CYCLES     = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_END   = 3'd3,
        ST_GAP        = 3'd4
    } arb_state_t;

endpackage : spi_arb_pkg
`default_nettype wire

// File: rtl/spi_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_rr_pick
//  Description : Two-way round-robin choice. When both requesters are valid
//                the one that did not win last time is chosen; a single valid
//                requester is always chosen.
//  Ports       : valid0, valid1 - request flags
//                lastGrant      - id of the previous winner
//                grant          - a winner exists this cycle
//                id             - winning requester (0/1)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_rr_pick
    import spi_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic lastGrant,
    output logic grant,
    output logic id
);

    assign grant = valid0 | valid1;
    assign id    = (valid0 & valid1) ? ~lastGrant : valid1;

endmodule : spi_rr_pick
`default_nettype wire

// File: rtl/spi_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_tx_arbiter
//  Description : Arbitrates two word requesters onto a single SPI transmitter
//                (SpiOut). A granted word is latched, SpiOut is started with a
//                one-cycle writeSPI strobe, the frame is tracked through chip
//                select, and an idle gap is enforced before the next grant.
//  Ports       : clock, resetN              - clock, async active-low reset
//                reqNValid/reqNData/reqNReady - requester N handshake (N=0,1)
//                spiData, writeSPI          - word and start strobe to SpiOut
//                masterChipSelectN          - SpiOut chip select (low = busy)
//                busy, grantId, errTimeout  - status
//  Options     : SPI_ARB_TIMEOUT_EN - bound both wait states by
//                TIMEOUT_CYCLES and abort the frame with errTimeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             req0Valid,
    input  logic [WIDTH-1:0] req0Data,
    output logic             req0Ready,
    input  logic             req1Valid,
    input  logic [WIDTH-1:0] req1Data,
    output logic             req1Ready,
    output logic [WIDTH-1:0] spiData,
    output logic             writeSPI,
    input  logic             masterChipSelectN,
    output logic             busy,
    output logic             grantId,
    output logic             errTimeout
);

    localparam logic [4:0] c_GAP_LIM = 5'(GAP_CYCLES);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic             r_last_grant;
    logic             r_grant_id;
    logic [WIDTH-1:0] r_spi_data;
    logic [3:0]       r_gap_cnt;

    logic             w_pick_valid;
    logic             w_pick_id;
    logic             w_take;
    logic             w_gap_done;
    logic             w_to_expired;
    logic             w_err_timeout;

    spi_rr_pick u_pick (
        .valid0    (req0Valid),
        .valid1    (req1Valid),
        .lastGrant (r_last_grant),
        .grant     (w_pick_valid),
        .id        (w_pick_id)
    );

    // Readies are combinational from the requester valids, so they are also
    // masked by resetN to stay low while reset is asserted.
    assign w_take    = (r_state == ST_IDLE) & w_pick_valid & resetN;
    assign req0Ready = w_take & ~w_pick_id;
    assign req1Ready = w_take &  w_pick_id;

    assign writeSPI   = (r_state == ST_LOAD);
    assign busy       = (r_state != ST_IDLE);
    assign spiData    = r_spi_data;
    assign grantId    = r_grant_id;
    assign errTimeout = w_err_timeout;

    // GAP always lasts at least one cycle; GAP_CYCLES of 0 and 1 behave alike.
    assign w_gap_done = ({1'b0, r_gap_cnt} + 5'd1) >= c_GAP_LIM;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned c_TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_in_wait;

    assign w_in_wait    = (r_state == ST_WAIT_START) | (r_state == ST_WAIT_END);
    assign w_to_expired = w_in_wait & (r_to_cnt == c_TO_LAST);

    // Counts clocks spent in the current wait state; any state change clears it.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_to_cnt <= '0;
        end else if (r_state != w_next_state) begin
            r_to_cnt <= '0;
        end else if (w_in_wait) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
    assign w_to_expired     = 1'b0;
`endif

    always_comb begin
        w_next_state  = r_state;
        w_err_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_next_state = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (!masterChipSelectN) begin
                    w_next_state = ST_WAIT_END;
                end else if (w_to_expired) begin
                    w_next_state  = ST_GAP;
                    w_err_timeout = 1'b1;
                end
            end
            ST_WAIT_END: begin
                if (masterChipSelectN) begin
                    w_next_state = ST_GAP;
                end else if (w_to_expired) begin
                    w_next_state  = ST_GAP;
                    w_err_timeout = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant bookkeeping and word capture; lastGrant resets to 1 so that
    // requester 0 wins the first contested grant.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_spi_data   <= '0;
        end else if (w_take) begin
            r_last_grant <= w_pick_id;
            r_grant_id   <= w_pick_id;
            r_spi_data   <= w_pick_id ? req1Data : req0Data;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_gap_cnt <= '0;
        end else if ((r_state == ST_GAP) && !w_gap_done) begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
        end else begin
            r_gap_cnt <= '0;
        end
    end

endmodule : spi_tx_arbiter
`default_nettype wire
